// File: rtl/approx_mul_err_acc_if.sv
// rtl/approx_mul_err_acc_if.sv - sample stream into the error accumulator
// Operand pair plus the approximate product under test, with valid/ready handshake.
interface approx_mul_err_acc_if #(
  parameter int N_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [N_W-1:0]     op_a;
  logic [N_W-1:0]     op_b;
  logic [2*N_W-1:0]   approx_prod;

  modport master (output in_valid, op_a, op_b, approx_prod, input in_ready);
  modport slave  (input in_valid, op_a, op_b, approx_prod, output in_ready);
endinterface

// File: rtl/approx_mul_err_acc.sv
// rtl/approx_mul_err_acc.sv - error statistics for an approximate NxN multiplier
// Optional signed error-bias accumulator sum_err is built when ERR_BIAS_EN is defined.
module approx_mul_err_acc #(
  parameter int N_W   = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  approx_mul_err_acc_if.slave  smp,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [ACC_W-1:0]     sum_abs_err,
  output logic [ACC_W-1:0]     sum_sq_err,
  output logic [2*N_W-1:0]     max_abs_err,
  output logic [N_W-1:0]       max_op_a,
  output logic [N_W-1:0]       max_op_b,
  output logic                 ovf
`ifdef ERR_BIAS_EN
  ,
  output logic signed [ACC_W-1:0] sum_err
`endif
);
  // Sums are formed one bit wider than the larger operand so the carry-out flags saturation.
  localparam int AB_W = ((ACC_W > 2*N_W) ? ACC_W : 2*N_W) + 1;
  localparam int SQ_W = ((ACC_W > 4*N_W) ? ACC_W : 4*N_W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] acc_cnt, n_lat;
  logic             accept, last_acc, start_ok;
  logic [2*N_W-1:0] exact, e_abs;
  logic [2*N_W:0]   e;
  logic             s1_valid, s1_nz;
  logic [2*N_W-1:0] s1_abs;
  logic [N_W-1:0]   s1_a, s1_b;
  logic [4*N_W-1:0] sq;
  logic [AB_W-1:0]  abs_sum;
  logic [SQ_W-1:0]  sq_sum;
  logic             abs_sat, sq_sat;

  assign smp.in_ready = (state == RUN) && (acc_cnt < n_lat);
  assign accept       = smp.in_valid && smp.in_ready;
  assign last_acc     = accept && ((acc_cnt + CNT_W'(1)) == n_lat);
  assign start_ok     = start && ((state == IDLE) || (state == DONE));

  assign exact = (2*N_W)'(smp.op_a) * (2*N_W)'(smp.op_b);
  assign e     = {1'b0, exact} - {1'b0, smp.approx_prod};
  assign e_abs = e[2*N_W] ? (2*N_W)'(-e) : e[2*N_W-1:0];

  assign sq      = (4*N_W)'(s1_abs) * (4*N_W)'(s1_abs);
  assign abs_sum = AB_W'(sum_abs_err) + AB_W'(s1_abs);
  assign sq_sum  = SQ_W'(sum_sq_err) + SQ_W'(sq);
  assign abs_sat = |abs_sum[AB_W-1:ACC_W];
  assign sq_sat  = |sq_sum[SQ_W-1:ACC_W];

`ifdef ERR_BIAS_EN
  localparam int BI_W = ((ACC_W > 2*N_W+1) ? ACC_W : 2*N_W+1) + 1;
  logic signed [2*N_W:0]  s1_err;
  logic signed [BI_W-1:0] bias_sum;
  logic                   bias_sat;
  logic [ACC_W-1:0]       bias_nxt;

  // Out of range whenever the bits above the result sign disagree with it.
  assign bias_sum = BI_W'(sum_err) + BI_W'(s1_err);
  assign bias_sat = (bias_sum[BI_W-1:ACC_W-1] != '0) && (bias_sum[BI_W-1:ACC_W-1] != '1);
  assign bias_nxt = !bias_sat ? bias_sum[ACC_W-1:0] :
                    bias_sum[BI_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_acc) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!s1_valid) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt     <= '0;
      n_lat       <= '0;
      s1_valid    <= 1'b0;
      s1_nz       <= 1'b0;
      s1_abs      <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      sample_cnt  <= '0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
      max_abs_err <= '0;
      max_op_a    <= '0;
      max_op_b    <= '0;
      ovf         <= 1'b0;
`ifdef ERR_BIAS_EN
      s1_err      <= '0;
      sum_err     <= '0;
`endif
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_abs <= e_abs;
        s1_nz  <= |e;
        s1_a   <= smp.op_a;
        s1_b   <= smp.op_b;
`ifdef ERR_BIAS_EN
        s1_err <= e;
`endif
      end
      if (start_ok) begin
        acc_cnt     <= '0;
        n_lat       <= num_samples;
        sample_cnt  <= '0;
        err_cnt     <= '0;
        sum_abs_err <= '0;
        sum_sq_err  <= '0;
        max_abs_err <= '0;
        max_op_a    <= '0;
        max_op_b    <= '0;
        ovf         <= 1'b0;
`ifdef ERR_BIAS_EN
        sum_err     <= '0;
`endif
      end else begin
        if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
        if (s1_valid) begin
          sample_cnt  <= sample_cnt + CNT_W'(1);
          err_cnt     <= err_cnt + CNT_W'(s1_nz);
          sum_abs_err <= abs_sat ? '1 : abs_sum[ACC_W-1:0];
          sum_sq_err  <= sq_sat  ? '1 : sq_sum[ACC_W-1:0];
          // Strict compare keeps the first sample on ties.
          if (s1_abs > max_abs_err) begin
            max_abs_err <= s1_abs;
            max_op_a    <= s1_a;
            max_op_b    <= s1_b;
          end
`ifdef ERR_BIAS_EN
          sum_err <= bias_nxt;
          ovf     <= ovf | abs_sat | sq_sat | bias_sat;
`else
          ovf     <= ovf | abs_sat | sq_sat;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_approx_mul_err_acc.sv
// tb/tb_approx_mul_err_acc.sv - randomized and directed checks of approx_mul_err_acc
// Reference statistics are recomputed from the list of accepted samples with plain arithmetic.
module tb_approx_mul_err_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        busy, done, ovf;
  logic [15:0] sample_cnt, err_cnt, max_abs_err;
  logic [47:0] sum_abs_err, sum_sq_err;
  logic [7:0]  max_op_a, max_op_b;
  approx_mul_err_acc_if #(.N_W(8)) bus ();

  logic        start2 = 1'b0;
  logic [15:0] ns2 = '0;
  logic        busy2, done2, ovf2;
  logic [15:0] sample_cnt2, err_cnt2, max_abs_err2;
  logic [19:0] sum_abs_err2, sum_sq_err2;
  logic [7:0]  max_op_a2, max_op_b2;
  approx_mul_err_acc_if #(.N_W(8)) bus2 ();
`ifdef ERR_BIAS_EN
  logic signed [47:0] sum_err;
  logic signed [19:0] sum_err2;
`endif

  approx_mul_err_acc #(.N_W(8), .CNT_W(16), .ACC_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .smp(bus),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_abs_err(sum_abs_err), .sum_sq_err(sum_sq_err), .max_abs_err(max_abs_err),
    .max_op_a(max_op_a), .max_op_b(max_op_b), .ovf(ovf)
`ifdef ERR_BIAS_EN
    , .sum_err(sum_err)
`endif
  );

  approx_mul_err_acc #(.N_W(8), .CNT_W(16), .ACC_W(20)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .num_samples(ns2), .smp(bus2),
    .busy(busy2), .done(done2), .sample_cnt(sample_cnt2), .err_cnt(err_cnt2),
    .sum_abs_err(sum_abs_err2), .sum_sq_err(sum_sq_err2), .max_abs_err(max_abs_err2),
    .max_op_a(max_op_a2), .max_op_b(max_op_b2), .ovf(ovf2)
`ifdef ERR_BIAS_EN
    , .sum_err(sum_err2)
`endif
  );

  int total = 0;
  int bad = 0;
  int qa[$], qb[$], qp[$];
  int ma[$], mb[$], mp[$];
  bit vpat[$];
  int start_mid_at = -1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int a, input int b, input int p);
    qa.push_back(a); qb.push_back(b); qp.push_back(p);
  endtask

  task automatic gen(input int n);
    int a, b, ex, p;
    for (int i = 0; i < n; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      ex = a * b;
      case ($urandom_range(0, 3))
        0: p = ex;
        1: p = ex + int'($urandom_range(0, 40)) - 20;
        2: p = int'($urandom_range(0, 65535));
        default: p = ex ^ int'($urandom_range(0, 255));
      endcase
      if (p < 0) p = 0;
      if (p > 65535) p = 65535;
      push(a, b, p);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cnt"}, 64'(sample_cnt), 64'd0);
    chk({tag, "_err"}, 64'(err_cnt), 64'd0);
    chk({tag, "_abs"}, 64'(sum_abs_err), 64'd0);
    chk({tag, "_sq"}, 64'(sum_sq_err), 64'd0);
    chk({tag, "_max"}, 64'({max_abs_err, max_op_a, max_op_b}), 64'd0);
    chk({tag, "_flags"}, 64'({ovf, busy, done, bus.in_ready}), 64'd0);
`ifdef ERR_BIAS_EN
    chk({tag, "_bias"}, 64'(sum_err), 64'd0);
`endif
  endtask

  task automatic check_stats(input string tag);
    longint e, av, sabs, ssq, bias, errs, mx, mxa, mxb, lim;
    sabs = 0; ssq = 0; bias = 0; errs = 0; mx = 0; mxa = 0; mxb = 0;
    lim = (longint'(1) << 48) - 1;
    foreach (ma[i]) begin
      e = longint'(ma[i]) * mb[i] - mp[i];
      av = (e < 0) ? -e : e;
      if (e != 0) errs++;
      sabs += av;
      ssq += av * av;
      bias += e;
      if (av > mx) begin mx = av; mxa = ma[i]; mxb = mb[i]; end
    end
    chk({tag, "_cnt"}, 64'(sample_cnt), 64'(ma.size()));
    chk({tag, "_err"}, 64'(err_cnt), 64'(errs));
    chk({tag, "_abs"}, 64'(sum_abs_err), 64'((sabs > lim) ? lim : sabs));
    chk({tag, "_sq"}, 64'(sum_sq_err), 64'((ssq > lim) ? lim : ssq));
    chk({tag, "_max"}, 64'(max_abs_err), 64'(mx));
    chk({tag, "_maxop"}, 64'({max_op_a, max_op_b}), 64'((mxa << 8) | mxb));
    chk({tag, "_ovf"}, 64'(ovf), 64'((sabs > lim) || (ssq > lim)));
`ifdef ERR_BIAS_EN
    chk({tag, "_bias"}, {{16{sum_err[47]}}, sum_err}, 64'(bias));
`endif
  endtask

  task automatic do_run(input string tag, input int n);
    int acc, cyc;
    bit v;
    ma.delete(); mb.delete(); mp.delete();
    num_samples = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (n == 0) begin
      chk({tag, "_done"}, 64'({busy, done}), 64'b01);
      check_stats(tag);
      return;
    end
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < 2000) begin
      v = (vpat.size() != 0) ? vpat.pop_front() : ($urandom_range(0, 3) != 0);
      if (qa.size() == 0) gen(1);
      bus.in_valid = v;
      bus.op_a = 8'(qa[0]);
      bus.op_b = 8'(qb[0]);
      bus.approx_prod = 16'(qp[0]);
      if (cyc == start_mid_at) begin
        start = 1'b1;
        num_samples = 16'd1;
      end
      chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
      tick();
      start = 1'b0;
      if (v) begin
        ma.push_back(qa.pop_front());
        mb.push_back(qb.pop_front());
        mp.push_back(qp.pop_front());
        acc++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    start_mid_at = -1;
    if (acc < n) chk({tag, "_accept_timeout"}, 64'(acc), 64'(n));
    chk({tag, "_ready_drop"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_busy"}, 64'({busy, done}), 64'b10);
    tick();
    chk({tag, "_done_early"}, 64'(done), 64'd0);
    tick();
    chk({tag, "_done"}, 64'({busy, done}), 64'b01);
    check_stats(tag);
  endtask

  initial begin
    int w;
    bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.approx_prod = '0;
    bus2.in_valid = 1'b0; bus2.op_a = '0; bus2.op_b = '0; bus2.approx_prod = '0;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    push(3, 5, 15); push(255, 255, 65025); push(0, 7, 0);
    do_run("exact", 3);

    push(255, 255, 65024); push(16, 16, 250); push(2, 3, 8);
    do_run("mixed", 3);

    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    #1 rst_n = 1'b1;
    tick();

    push(16, 16, 250); push(1, 1, 7); push(2, 3, 8); push(40, 2, 75);
    do_run("tie", 4);
    chk("tie_op", 64'({max_op_a, max_op_b}), 64'h1010);

    push(1, 2, 3); push(4, 5, 20); push(6, 7, 40); push(8, 9, 72);
    vpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_run("hs", 4);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("hs_extra", 64'({sample_cnt, bus.in_ready}), 64'({16'd4, 1'b0}));
    qa.delete(); qb.delete(); qp.delete();

    gen(5);
    start_mid_at = 2;
    do_run("mid_start", 5);

    do_run("zero", 0);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(10, 40));
      gen(n);
      do_run("rand", n);
    end

    num_samples = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.op_a = 8'd9; bus.op_b = 8'd9; bus.approx_prod = 16'd1;
      tick();
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("abort");
    #1 rst_n = 1'b1;
    tick();

    ns2 = 16'd20;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    bus2.in_valid = 1'b1; bus2.op_a = 8'd0; bus2.op_b = 8'd0; bus2.approx_prod = 16'hFFFF;
    for (int i = 0; i < 20; i++) tick();
    bus2.in_valid = 1'b0;
    w = 0;
    while (!done2 && w < 10) begin tick(); w++; end
    chk("sat_done", 64'(done2), 64'd1);
    chk("sat_cnt", 64'(sample_cnt2), 64'd20);
    chk("sat_sq", 64'(sum_sq_err2), 64'hFFFFF);
    chk("sat_abs", 64'(sum_abs_err2), 64'hFFFFF);
    chk("sat_ovf", 64'(ovf2), 64'd1);
    chk("sat_max", 64'(max_abs_err2), 64'hFFFF);
`ifdef ERR_BIAS_EN
    chk("sat_bias", 64'(sum_err2), 64'h80000);
`endif
    ns2 = 16'd0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("sat_clear", 64'({ovf2, done2, sum_sq_err2}), 64'({1'b0, 1'b1, 20'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
